// File: rtl/gpio_pkg.sv
// Shared definitions for the multi-port GPIO: register map, port stride and
// the decoded register-select type.
package gpio_pkg;

   localparam logic [4:0] OFS_DDR     = 5'h00;
   localparam logic [4:0] OFS_OUT     = 5'h04;
   localparam logic [4:0] OFS_IN      = 5'h08;
   localparam logic [4:0] OFS_SET     = 5'h0C;
   localparam logic [4:0] OFS_CLR     = 5'h10;
   localparam logic [4:0] OFS_RISE_EN = 5'h14;
   localparam logic [4:0] OFS_FALL_EN = 5'h18;
   localparam logic [4:0] OFS_STATUS  = 5'h1C;

   localparam int PORT_STRIDE = 'h20;

   typedef enum logic [2:0] {
      SEL_DDR     = 3'd0,
      SEL_OUT     = 3'd1,
      SEL_IN      = 3'd2,
      SEL_SET     = 3'd3,
      SEL_CLR     = 3'd4,
      SEL_RISE_EN = 3'd5,
      SEL_FALL_EN = 3'd6,
      SEL_STATUS  = 3'd7
   } reg_sel_t;

   // Map the word offset within a port window (addr[4:2]) to a register select.
   function automatic reg_sel_t decode_ofs(input logic [2:0] word_ofs);
      reg_sel_t sel;
      sel = SEL_DDR;
      case ({word_ofs, 2'b00})
         OFS_DDR:     sel = SEL_DDR;
         OFS_OUT:     sel = SEL_OUT;
         OFS_IN:      sel = SEL_IN;
         OFS_SET:     sel = SEL_SET;
         OFS_CLR:     sel = SEL_CLR;
         OFS_RISE_EN: sel = SEL_RISE_EN;
         OFS_FALL_EN: sel = SEL_FALL_EN;
         OFS_STATUS:  sel = SEL_STATUS;
         default:     sel = SEL_DDR;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/gpio_multiport_port.sv
// One GPIO port: DDR/OUT registers with atomic set/clear, 2-flop pin
// synchroniser plus previous-sample flop, edge detection and sticky W1C status.
module gpio_port
   import gpio_pkg::*;
#(
   parameter int GPIO_WIDTH = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  we_i,
   input  reg_sel_t              reg_sel_i,
   input  logic [GPIO_WIDTH-1:0] wdata_i,
   input  logic [GPIO_WIDTH-1:0] pin_i,
   output logic [GPIO_WIDTH-1:0] rdata_o,
   output logic [GPIO_WIDTH-1:0] out_o,
   output logic [GPIO_WIDTH-1:0] ddr_o,
   output logic                  status_any_o
);

   logic [GPIO_WIDTH-1:0] ddr_q, ddr_d;
   logic [GPIO_WIDTH-1:0] out_q, out_d;
   logic [GPIO_WIDTH-1:0] rise_en_q, rise_en_d;
   logic [GPIO_WIDTH-1:0] fall_en_q, fall_en_d;
   logic [GPIO_WIDTH-1:0] status_q, status_d;
   logic [GPIO_WIDTH-1:0] sync1_q, sync2_q, prev_q;
   logic [GPIO_WIDTH-1:0] w1c_mask, rise, fall;

   // Register write decode and status next-state; a new event beats a W1C.
   always_comb begin
      ddr_d     = ddr_q;
      out_d     = out_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      w1c_mask  = '0;
      if (we_i) begin
         case (reg_sel_i)
            SEL_DDR:     ddr_d     = wdata_i;
            SEL_OUT:     out_d     = wdata_i;
            SEL_SET:     out_d     = out_q | wdata_i;
            SEL_CLR:     out_d     = out_q & ~wdata_i;
            SEL_RISE_EN: rise_en_d = wdata_i;
            SEL_FALL_EN: fall_en_d = wdata_i;
            SEL_STATUS:  w1c_mask  = wdata_i;
            default:     ;
         endcase
      end
      rise     = sync2_q & ~prev_q & rise_en_q;
      fall     = ~sync2_q & prev_q & fall_en_q;
      status_d = (status_q & ~w1c_mask) | rise | fall;
   end

   // State registers and pin sampling pipeline.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ddr_q     <= '0;
         out_q     <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         status_q  <= '0;
         sync1_q   <= '0;
         sync2_q   <= '0;
         prev_q    <= '0;
      end else begin
         ddr_q     <= ddr_d;
         out_q     <= out_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         status_q  <= status_d;
         sync1_q   <= pin_i;
         sync2_q   <= sync1_q;
         prev_q    <= sync2_q;
      end
   end

   // Read mux; SET and CLR are write-only and read back as zero.
   always_comb begin
      rdata_o = '0;
      case (reg_sel_i)
         SEL_DDR:     rdata_o = ddr_q;
         SEL_OUT:     rdata_o = out_q;
         SEL_IN:      rdata_o = sync2_q;
         SEL_RISE_EN: rdata_o = rise_en_q;
         SEL_FALL_EN: rdata_o = fall_en_q;
         SEL_STATUS:  rdata_o = status_q;
         default:     rdata_o = '0;
      endcase
   end

   assign out_o        = out_q;
   assign ddr_o        = ddr_q;
   assign status_any_o = |status_q;

endmodule

// File: rtl/gpio_multiport.sv
// Multi-port GPIO on the peripheral bus: address decode, registered read
// data and the combined interrupt request.
module gpio_multiport
   import gpio_pkg::*;
#(
   parameter int MEMORY_BUS_WIDTH = 32,
   parameter int ADDR_WIDTH       = 16,
   parameter int NUM_PORTS        = 4,
   parameter int GPIO_WIDTH       = 16
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [ADDR_WIDTH-1:0]           addr_i,
   input  logic [MEMORY_BUS_WIDTH-1:0]     data_i,
   output logic [MEMORY_BUS_WIDTH-1:0]     data_o,
   input  logic                            sel_i,
   input  logic                            wr_i,
   output logic                            irq_o,
   input  logic [NUM_PORTS*GPIO_WIDTH-1:0] gpio_in,
   output logic [NUM_PORTS*GPIO_WIDTH-1:0] gpio_out,
   output logic [NUM_PORTS*GPIO_WIDTH-1:0] gpio_ddr
);

   localparam int PIDX_LSB = $clog2(PORT_STRIDE);
   // Index field is wide enough to hold NUM_PORTS itself, so the window just
   // past the last port decodes as out-of-range instead of aliasing port 0.
   localparam int PIDX_W   = $clog2(NUM_PORTS + 1);

   logic [PIDX_W-1:0]           port_idx;
   reg_sel_t                    reg_sel;
   logic [GPIO_WIDTH-1:0]       wdata;
   logic [NUM_PORTS-1:0]        port_we;
   logic [NUM_PORTS-1:0]        port_status_any;
   logic [GPIO_WIDTH-1:0]       port_rdata [NUM_PORTS];
   logic [GPIO_WIDTH-1:0]       rd_word;
   logic [MEMORY_BUS_WIDTH-1:0] data_q, data_d;
   logic                        irq_q, irq_d;
   logic                        unused_bits;

   assign port_idx    = addr_i[PIDX_LSB +: PIDX_W];
   assign reg_sel     = decode_ofs(addr_i[4:2]);
   assign wdata       = data_i[GPIO_WIDTH-1:0];
   assign unused_bits = ^{addr_i, data_i};

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign port_we[p] = sel_i & wr_i & (port_idx == PIDX_W'(p));

      gpio_port #(
         .GPIO_WIDTH (GPIO_WIDTH)
      ) u_port (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .we_i         (port_we[p]),
         .reg_sel_i    (reg_sel),
         .wdata_i      (wdata),
         .pin_i        (gpio_in[p*GPIO_WIDTH +: GPIO_WIDTH]),
         .rdata_o      (port_rdata[p]),
         .out_o        (gpio_out[p*GPIO_WIDTH +: GPIO_WIDTH]),
         .ddr_o        (gpio_ddr[p*GPIO_WIDTH +: GPIO_WIDTH]),
         .status_any_o (port_status_any[p])
      );
   end

   // Select the addressed port's read word; out-of-range ports read zero.
   always_comb begin
      rd_word = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (port_idx == PIDX_W'(p)) rd_word = port_rdata[p];
      end
   end

   // Read data is captured only on a read strobe and held otherwise.
   always_comb begin
      data_d = data_q;
      if (sel_i && !wr_i) data_d = MEMORY_BUS_WIDTH'(rd_word);
      irq_d = |port_status_any;
   end

   // Bus-side output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         irq_q  <= irq_d;
      end
   end

   assign data_o = data_q;
   assign irq_o  = irq_q;

endmodule

// File: tb/tb_gpio_multiport.sv
module tb_gpio_multiport;

   localparam int NP = 4;
   localparam int GW = 16;
   localparam int BW = 32;
   localparam int AW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, sel, wr;
   logic [AW-1:0]    addr;
   logic [BW-1:0]    wdata, rdata;
   logic             irq;
   logic [NP*GW-1:0] pins, gout, gddr;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: register contents per port plus a short history of pin
   // samples (index 0 = newest). IN is the sample one edge older than the
   // newest; an edge event compares the two samples behind that.
   logic [GW-1:0] m_ddr [NP];
   logic [GW-1:0] m_out [NP];
   logic [GW-1:0] m_ren [NP];
   logic [GW-1:0] m_fen [NP];
   logic [GW-1:0] m_st  [NP];
   logic [GW-1:0] m_smp [NP][3];
   logic [BW-1:0] m_data;
   logic          m_irq;

   gpio_multiport #(
      .MEMORY_BUS_WIDTH (BW),
      .ADDR_WIDTH       (AW),
      .NUM_PORTS        (NP),
      .GPIO_WIDTH       (GW)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .addr_i   (addr),
      .data_i   (wdata),
      .data_o   (rdata),
      .sel_i    (sel),
      .wr_i     (wr),
      .irq_o    (irq),
      .gpio_in  (pins),
      .gpio_out (gout),
      .gpio_ddr (gddr)
   );

   task automatic model_edge();
      int            pi, ofs;
      logic [GW-1:0] wd, ev, w1c, val, now_s, old_s;
      logic          any;
      pi  = int'(addr[7:5]);
      ofs = int'(addr[4:2]);
      wd  = wdata[GW-1:0];
      if (rst) begin
         for (int p = 0; p < NP; p++) begin
            m_ddr[p] = '0; m_out[p] = '0; m_ren[p] = '0; m_fen[p] = '0; m_st[p] = '0;
            for (int k = 0; k < 3; k++) m_smp[p][k] = '0;
         end
         m_data = '0;
         m_irq  = 1'b0;
         return;
      end
      any = 1'b0;
      for (int p = 0; p < NP; p++) any |= (m_st[p] != 0);
      if (sel && !wr) begin
         val = '0;
         if (pi < NP) begin
            case (ofs)
               0: val = m_ddr[pi];
               1: val = m_out[pi];
               2: val = m_smp[pi][1];
               5: val = m_ren[pi];
               6: val = m_fen[pi];
               7: val = m_st[pi];
               default: val = '0;
            endcase
         end
         m_data = BW'(val);
      end
      for (int p = 0; p < NP; p++) begin
         now_s = m_smp[p][1];
         old_s = m_smp[p][2];
         ev  = (now_s & ~old_s & m_ren[p]) | (~now_s & old_s & m_fen[p]);
         w1c = '0;
         if (sel && wr && pi == p) begin
            case (ofs)
               0: m_ddr[p] = wd;
               1: m_out[p] = wd;
               3: m_out[p] = m_out[p] | wd;
               4: m_out[p] = m_out[p] & ~wd;
               5: m_ren[p] = wd;
               6: m_fen[p] = wd;
               7: w1c = wd;
               default: ;
            endcase
         end
         m_st[p]    = (m_st[p] & ~w1c) | ev;
         m_smp[p][2] = m_smp[p][1];
         m_smp[p][1] = m_smp[p][0];
         m_smp[p][0] = pins[p*GW +: GW];
      end
      m_irq = any;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic bus(input logic s, input logic w, input logic [AW-1:0] a, input logic [BW-1:0] d);
      sel = s; wr = w; addr = a; wdata = d;
      tick();
      sel = 1'b0; wr = 1'b0;
   endtask

   function automatic logic [AW-1:0] ra(input int p, input int ofs);
      return AW'(p * 32 + ofs);
   endfunction

   task automatic wr_reg(input int p, input int ofs, input logic [BW-1:0] d);
      bus(1'b1, 1'b1, ra(p, ofs), d);
   endtask

   task automatic rd_reg(input int p, input int ofs);
      bus(1'b1, 1'b0, ra(p, ofs), '0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bus(1'b0, 1'b0, '0, '0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      for (int o = 0; o < 8; o++) begin
         rd_reg(0, o * 4);
         n_checks++;
         if (rdata !== 32'h0) $display("FAIL reset_read ofs=%0h got %h expected %h", o * 4, rdata, 32'h0);
         else n_pass++;
      end
      n_checks++;
      if (gout !== '0) $display("FAIL reset_gpio_out got %h expected 0", gout); else n_pass++;
      n_checks++;
      if (gddr !== '0) $display("FAIL reset_gpio_ddr got %h expected 0", gddr); else n_pass++;
      n_checks++;
      if (irq !== 1'b0) $display("FAIL reset_irq got %b expected 0", irq); else n_pass++;
   endtask

   task automatic test_outputs();
      wr_reg(1, 'h00, 32'h0000_00FF);
      wr_reg(1, 'h04, 32'h0000_1234);
      wr_reg(1, 'h0C, 32'h0000_8000);
      wr_reg(1, 'h10, 32'h0000_0004);
      n_checks++;
      if (gout[1*GW +: GW] !== 16'h9230) $display("FAIL out_port1 got %h expected %h", gout[1*GW +: GW], 16'h9230);
      else n_pass++;
      n_checks++;
      if (gddr[1*GW +: GW] !== 16'h00FF) $display("FAIL ddr_port1 got %h expected %h", gddr[1*GW +: GW], 16'h00FF);
      else n_pass++;
      rd_reg(1, 'h04);
      n_checks++;
      if (rdata !== 32'h0000_9230) $display("FAIL read_out_port1 got %h expected %h", rdata, 32'h9230); else n_pass++;
      rd_reg(1, 'h0C);
      n_checks++;
      if (rdata !== 32'h0) $display("FAIL read_set_wo got %h expected 0", rdata); else n_pass++;
      wr_reg(3, 'h00, 32'hFFFF_FFFF);
      rd_reg(3, 'h00);
      n_checks++;
      if (rdata !== 32'h0000_FFFF) $display("FAIL upper_bits_read got %h expected %h", rdata, 32'hFFFF); else n_pass++;
      wr_reg(3, 'h00, 32'h0);
   endtask

   task automatic test_rise_irq();
      wr_reg(2, 'h14, 32'h1);
      pins[2*GW] = 1'b1;
      idle(1);                                   // E0
      rd_reg(2, 'h08);                           // E1: samples IN before E1
      n_checks++;
      if (rdata !== 32'h0) $display("FAIL rise_in_e1 got %h expected 0", rdata); else n_pass++;
      rd_reg(2, 'h08);                           // E2
      n_checks++;
      if (rdata !== 32'h1) $display("FAIL rise_in_e2 got %h expected 1", rdata); else n_pass++;
      n_checks++;
      if (irq !== 1'b0) $display("FAIL rise_irq_e2 got %b expected 0", irq); else n_pass++;
      rd_reg(2, 'h1C);                           // E3
      n_checks++;
      if (rdata !== 32'h1) $display("FAIL rise_status got %h expected 1", rdata); else n_pass++;
      n_checks++;
      if (irq !== 1'b1) $display("FAIL rise_irq_e3 got %b expected 1", irq); else n_pass++;
      wr_reg(2, 'h1C, 32'h1);
      n_checks++;
      if (irq !== 1'b1) $display("FAIL w1c_irq_n got %b expected 1", irq); else n_pass++;
      idle(1);
      n_checks++;
      if (irq !== 1'b0) $display("FAIL w1c_irq_n1 got %b expected 0", irq); else n_pass++;
   endtask

   task automatic test_fall_w1c();
      wr_reg(0, 'h18, 32'h3);
      pins[1:0] = 2'b11;
      idle(5);
      pins[1:0] = 2'b00;
      idle(3);
      rd_reg(0, 'h1C);
      n_checks++;
      if (rdata !== 32'h3) $display("FAIL fall_status got %h expected 3", rdata); else n_pass++;
      pins[0] = 1'b1;
      idle(5);
      pins[0] = 1'b0;
      idle(2);                                   // E0, E1
      wr_reg(0, 'h1C, 32'h1);                    // E2: W1C collides with new event
      rd_reg(0, 'h1C);
      n_checks++;
      if (rdata !== 32'h3) $display("FAIL w1c_collision got %h expected 3", rdata); else n_pass++;
      wr_reg(0, 'h18, 32'h0);
      rd_reg(0, 'h1C);
      n_checks++;
      if (rdata !== 32'h3) $display("FAIL fall_en_clear_keeps got %h expected 3", rdata); else n_pass++;
      wr_reg(0, 'h1C, 32'h3);
      rd_reg(0, 'h1C);
      n_checks++;
      if (rdata !== 32'h0) $display("FAIL fall_w1c_all got %h expected 0", rdata); else n_pass++;
      n_checks++;
      if (irq !== 1'b0) $display("FAIL fall_irq_clear got %b expected 0", irq); else n_pass++;
   endtask

   task automatic test_oob();
      logic [NP*GW-1:0] ddr_before, out_before;
      ddr_before = gddr;
      out_before = gout;
      bus(1'b1, 1'b1, 16'h0080, 32'h0000_FFFF);
      bus(1'b1, 1'b1, 16'h0084, 32'h0000_FFFF);
      n_checks++;
      if (gddr !== ddr_before) $display("FAIL oob_ddr got %h expected %h", gddr, ddr_before); else n_pass++;
      n_checks++;
      if (gout !== out_before) $display("FAIL oob_out got %h expected %h", gout, out_before); else n_pass++;
      rd_reg(1, 'h04);
      bus(1'b1, 1'b0, 16'h0080, '0);
      n_checks++;
      if (rdata !== 32'h0) $display("FAIL oob_read got %h expected 0", rdata); else n_pass++;
   endtask

   task automatic test_reset_mid();
      wr_reg(3, 'h14, 32'h1);
      pins[3*GW] = 1'b1;
      idle(4);
      n_checks++;
      if (irq !== 1'b1) $display("FAIL pre_reset_irq got %b expected 1", irq); else n_pass++;
      rd_reg(3, 'h1C);
      n_checks++;
      if (rdata !== 32'h1) $display("FAIL pre_reset_status got %h expected 1", rdata); else n_pass++;
      rst = 1'b1;
      bus(1'b1, 1'b1, ra(3, 'h04), 32'h0000_FFFF);
      rst = 1'b0;
      n_checks++;
      if (irq !== 1'b0) $display("FAIL mid_reset_irq got %b expected 0", irq); else n_pass++;
      n_checks++;
      if (rdata !== 32'h0) $display("FAIL mid_reset_data got %h expected 0", rdata); else n_pass++;
      n_checks++;
      if (gout !== '0) $display("FAIL mid_reset_out got %h expected 0", gout); else n_pass++;
      idle(5);
      rd_reg(3, 'h1C);
      n_checks++;
      if (rdata !== 32'h0) $display("FAIL post_reset_status got %h expected 0", rdata); else n_pass++;
      n_checks++;
      if (irq !== 1'b0) $display("FAIL post_reset_irq got %b expected 0", irq); else n_pass++;
   endtask

   task automatic test_random();
      logic [NP*GW-1:0] exp_out, exp_ddr;
      logic [AW-1:0]    a;
      int               errs;
      errs = 0;
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 3) == 0) pins = pins ^ (NP*GW)'(64'(1) << $urandom_range(0, NP*GW-1));
         a = AW'({$urandom_range(0, 255), 8'h00});
         a[7:5] = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
         a[4:2] = 3'($urandom_range(0, 7));
         a[1:0] = 2'($urandom_range(0, 3));
         sel   = ($urandom_range(0, 3) != 0);
         wr    = ($urandom_range(0, 1) == 1);
         addr  = a;
         wdata = $urandom();
         if (a[4:2] == 3'd7 && $urandom_range(0, 1) == 1) wdata = 32'h0;
         tick();
         sel = 1'b0; wr = 1'b0;
         for (int p = 0; p < NP; p++) begin
            exp_out[p*GW +: GW] = m_out[p];
            exp_ddr[p*GW +: GW] = m_ddr[p];
         end
         n_checks++;
         if (rdata !== m_data) begin
            if (errs < 10) $display("FAIL rand_data cyc=%0d got %h expected %h", c, rdata, m_data);
            errs++;
         end else n_pass++;
         n_checks++;
         if (irq !== m_irq) begin
            if (errs < 10) $display("FAIL rand_irq cyc=%0d got %b expected %b", c, irq, m_irq);
            errs++;
         end else n_pass++;
         n_checks++;
         if (gout !== exp_out) begin
            if (errs < 10) $display("FAIL rand_out cyc=%0d got %h expected %h", c, gout, exp_out);
            errs++;
         end else n_pass++;
         n_checks++;
         if (gddr !== exp_ddr) begin
            if (errs < 10) $display("FAIL rand_ddr cyc=%0d got %h expected %h", c, gddr, exp_ddr);
            errs++;
         end else n_pass++;
      end
   endtask

   initial begin
      rst   = 1'b1;
      sel   = 1'b0;
      wr    = 1'b0;
      addr  = '0;
      wdata = '0;
      pins  = '0;
      test_reset();
      test_outputs();
      test_rise_irq();
      test_fall_w1c();
      test_oob();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
